pes_sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8x16 sync FIFO.

---
 rtl/pes_sfifo_pkg.sv | 14 +
 rtl/pes_sfifo_ram.sv | 48 ++++
 rtl/pes_sync_fifo_param.sv | 114 +++++++++++
 tb/tb_pes_sync_fifo_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pes_sfifo_pkg.sv
// Shared defaults and derived sizes for the parametrised sync FIFO and its bench.
// Optional build macro: SFIFO_FWFT_EN (first-word-fall-through read port).
package pes_sfifo_pkg;

  localparam int SFIFO_DATA_W = 8;
  localparam int SFIFO_ADDR_W = 4;
  localparam int SFIFO_AF_LVL = 14;
  localparam int SFIFO_AE_LVL = 2;

  localparam int SFIFO_DEPTH  = 1 << SFIFO_ADDR_W;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int SFIFO_PTR_W  = SFIFO_ADDR_W + 1;

endpackage

// File: rtl/pes_sfifo_ram.sv
// Storage array for pes_sync_fifo_param: one write port plus one read port.
// With SFIFO_FWFT_EN the read port is a combinational tap, otherwise a registered read.
module pes_sfifo_ram
  import pes_sfifo_pkg::*;
#(
  parameter int DATA_W = SFIFO_DATA_W,
  parameter int ADDR_W = SFIFO_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef SFIFO_FWFT_EN
  logic unused_ctrl;
  assign unused_ctrl = rst_i ^ re_i;
  assign rdata_o     = mem_q[raddr_i];
`else
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read sees the pre-write word, giving read-before-write at full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/pes_sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost flags and sticky error flags.
// Build macro SFIFO_FWFT_EN selects first-word-fall-through output; default is registered read.
module pes_sync_fifo_param
  import pes_sfifo_pkg::*;
#(
  parameter int DATA_W = SFIFO_DATA_W,
  parameter int ADDR_W = SFIFO_ADDR_W,
  parameter int AF_LVL = SFIFO_AF_LVL,
  parameter int AE_LVL = SFIFO_AE_LVL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] iData,
  input  logic              clr_err,
  output logic [DATA_W-1:0] oData,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_C = PTR_W'(AF_LVL);
  localparam logic [PTR_W-1:0] AE_C = PTR_W'(AE_LVL);

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [PTR_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_ok, wr_ok;
  logic [DATA_W-1:0] ram_rdata;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[ADDR_W] != rp_q[ADDR_W]) &&
                 (wp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]);

  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;

    if (wr_ok) wp_d = wp_q + PTR_W'(1);
    if (rd_ok) rp_d = rp_q + PTR_W'(1);

    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + PTR_W'(1);
      2'b01:   cnt_d = cnt_q - PTR_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear first so a fresh error in the same cycle wins.
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (write && !wr_ok) ovf_d = 1'b1;
    if (read && empty)   udf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  pes_sfifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (wr_ok & ~RST),
    .waddr_i (wp_q[ADDR_W-1:0]),
    .wdata_i (iData),
    .re_i    (rd_ok),
    .raddr_i (rp_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

`ifdef SFIFO_FWFT_EN
  assign oData = empty ? '0 : ram_rdata;
`else
  assign oData = ram_rdata;
`endif

  assign count        = cnt_q;
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_pes_sync_fifo_param.sv
// Self-checking bench for pes_sync_fifo_param against a queue-based reference model.
// Honours SFIFO_FWFT_EN when the design is built with it.
module tb_pes_sync_fifo_param;
  import pes_sfifo_pkg::*;

  localparam int DW    = SFIFO_DATA_W;
  localparam int DEPTH = SFIFO_DEPTH;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [DW-1:0]     iData = '0;
  logic              clr_err = 1'b0;
  logic [DW-1:0]     oData;
  logic              full, empty, almost_full, almost_empty;
  logic [SFIFO_ADDR_W:0] count;
  logic              overflow, underflow;

  int n_asrt = 0;
  int n_fail = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last;
  logic          m_ovf, m_udf;

  always #5 CLK = ~CLK;

  pes_sync_fifo_param dut (
    .CLK          (CLK),
    .RST          (RST),
    .write        (write),
    .read         (read),
    .iData        (iData),
    .clr_err      (clr_err),
    .oData        (oData),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  function automatic logic [DW-1:0] exp_od();
`ifdef SFIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : '0;
`else
    return m_last;
`endif
  endfunction

  function automatic logic [DW+SFIFO_ADDR_W+6:0] exp_vec();
    int n = mq.size();
    return {exp_od(), (SFIFO_ADDR_W+1)'(n), n == DEPTH, n == 0,
            n >= SFIFO_AF_LVL, n <= SFIFO_AE_LVL, m_ovf, m_udf};
  endfunction

  // Drive one cycle of inputs, advance the model by the FIFO rules, sample after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic c, input logic rs);
    bit was_empty, was_full, rd, wr;
    write = w; read = r; iData = d; clr_err = c; RST = rs;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    rd = r && !was_empty;
    wr = w && (!was_full || rd);
    if (rs) begin
      mq.delete();
      m_last = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (rd) m_last = mq.pop_front();
      if (wr) mq.push_back(d);
      if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (w && !wr) m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
    end
    @(posedge CLK); #1;
    write = 1'b0; read = 1'b0; clr_err = 1'b0; RST = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, '0, 0, 1);
    n_asrt++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_asrt++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=1100", {empty, almost_empty, full, almost_full}); end
    n_asrt++; if (oData !== '0) begin n_fail++; $display("FAIL reset_odata got=%h exp=00", oData); end
    n_asrt++; if ({overflow, underflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, DW'(i), 0, 0);
      if (i == SFIFO_AF_LVL - 2) begin
        n_asrt++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_before got=%b exp=0", almost_full); end
      end
      if (i == SFIFO_AF_LVL - 1) begin
        n_asrt++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_at_lvl got=%b exp=1", almost_full); end
      end
      if (i == DEPTH - 2) begin
        n_asrt++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_early got=%b exp=0", full); end
      end
    end
    n_asrt++; if ({full, count} !== {1'b1, 5'd16}) begin
      n_fail++; $display("FAIL fill_full got=%b/%0d exp=1/16", full, count); end
    step(1, 0, 8'hAA, 0, 0);
    n_asrt++; if ({overflow, count} !== {1'b1, 5'd16}) begin
      n_fail++; $display("FAIL ovf_drop got=%b/%0d exp=1/16", overflow, count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, '0, 0, 0);
      n_asrt++; if (oData !== exp_od()) begin
        n_fail++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, oData, exp_od()); end
    end
`ifndef SFIFO_FWFT_EN
    n_asrt++; if (oData !== 8'h0F) begin n_fail++; $display("FAIL drain_last got=%h exp=0f", oData); end
`endif
    n_asrt++; if ({empty, count} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    step(0, 0, '0, 1, 0);
    n_asrt++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i), 0, 0);
    step(1, 1, 8'h55, 0, 0);
`ifndef SFIFO_FWFT_EN
    n_asrt++; if (oData !== 8'h00) begin n_fail++; $display("FAIL full_rw_data got=%h exp=00", oData); end
`endif
    n_asrt++; if ({count, overflow} !== {5'd16, 1'b0}) begin
      n_fail++; $display("FAIL full_rw_cnt got=%0d/%b exp=16/0", count, overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, '0, 0, 0);
      n_asrt++; if (oData !== exp_od()) begin
        n_fail++; $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, oData, exp_od()); end
    end
`ifndef SFIFO_FWFT_EN
    n_asrt++; if (oData !== 8'h55) begin n_fail++; $display("FAIL full_rw_tail got=%h exp=55", oData); end
`endif
  endtask

  task automatic test_empty_rw();
    step(1, 1, 8'h3C, 0, 0);
    n_asrt++; if ({underflow, count} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL empty_rw got=%b/%0d exp=1/1", underflow, count); end
`ifdef SFIFO_FWFT_EN
    n_asrt++; if (oData !== 8'h3C) begin n_fail++; $display("FAIL empty_rw_head got=%h exp=3c", oData); end
`endif
    step(0, 1, '0, 0, 0);
`ifndef SFIFO_FWFT_EN
    n_asrt++; if (oData !== 8'h3C) begin n_fail++; $display("FAIL empty_rw_read got=%h exp=3c", oData); end
`endif
    n_asrt++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_rw_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap_clr();
    logic [DW-1:0] d;
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom);
      step(1, 0, d, 0, 0);
      step(0, 1, '0, 0, 0);
      n_asrt++; if (oData !== exp_od()) begin
        n_fail++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, oData, exp_od()); end
    end
    step(0, 1, '0, 1, 0);
    n_asrt++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%b exp=1", underflow); end
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i), 0, 0);
    step(1, 0, 8'h99, 0, 0);
    n_asrt++; if ({overflow, underflow} !== 2'b11) begin
      n_fail++; $display("FAIL both_err got=%b exp=11", {overflow, underflow}); end
    step(0, 0, '0, 1, 0);
    n_asrt++; if ({overflow, underflow} !== 2'b00) begin
      n_fail++; $display("FAIL clr_err got=%b exp=00", {overflow, underflow}); end
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step(1, 0, DW'($urandom), 0, 0);
    n_asrt++; if (count !== 5'd7) begin n_fail++; $display("FAIL mid_count got=%0d exp=7", count); end
    step(1, 1, 8'hEE, 1, 1);
    n_asrt++; if ({empty, count, oData} !== {1'b1, 5'd0, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset got=%b/%0d/%h exp=1/0/00", empty, count, oData); end
    step(1, 0, 8'h77, 0, 0);
    n_asrt++; if (oData !== exp_od()) begin n_fail++; $display("FAIL mid_head got=%h exp=%h", oData, exp_od()); end
    step(0, 0, '0, 0, 1);
  endtask

  task automatic test_random();
    logic [DW+SFIFO_ADDR_W+6:0] got, exp;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
      got = {oData, count, full, empty, almost_full, almost_empty, overflow, underflow};
      exp = exp_vec();
      n_asrt++; if (got !== exp) begin
        n_fail++; $display("FAIL random[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  initial begin
    m_last = '0; m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap_clr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
